// File: rtl/ws2812_bit_encoder.sv
// ws2812_bit_encoder: serialises 24-bit GRB words onto one WS2812 line, with a one-word holding register and a latch gap at frame end
module ws2812_bit_encoder #(
    parameter int T0H_CYC = 16,
    parameter int T1H_CYC = 32,
    parameter int BIT_CYC = 50,
    parameter int RST_CYC = 2400,
    parameter int CNT_W   = 12
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        pix_valid_in,
    input  logic [23:0] pix_data_in,
    input  logic        pix_last_in,
    output logic        pix_ready_out,
    output logic        busy_out,
    output logic        underrun_out,
    output logic        frame_done_out,
    output logic        ws2812_data_out
);
    localparam logic [CNT_W-1:0] L_BIT_LAST = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] L_RST_LAST = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] L_T0H      = CNT_W'(T0H_CYC);
    localparam logic [CNT_W-1:0] L_T1H      = CNT_W'(T1H_CYC);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAIT, S_LATCH} state_t;

    state_t           r_state, w_state_nxt;
    logic [23:0]      r_hold_data, r_shift;
    logic             r_hold_last, r_hold_full, r_cur_last;
    logic [4:0]       r_bit_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_data, r_underrun, r_frame_done;
    logic             w_accept, w_load, w_bit_end, w_pix_end, w_latch_end, w_high;

    assign w_accept    = pix_valid_in & ~r_hold_full;
    assign w_bit_end   = r_cnt == L_BIT_LAST;
    assign w_pix_end   = (r_state == S_SHIFT) && w_bit_end && (r_bit_idx == 5'd0);
    assign w_latch_end = (r_state == S_LATCH) && (r_cnt == L_RST_LAST);
    assign w_high      = r_cnt < (r_shift[23] ? L_T1H : L_T0H);

    assign pix_ready_out   = ~r_hold_full;
    assign busy_out        = r_state != S_IDLE;
    assign underrun_out    = r_underrun;
    assign frame_done_out  = r_frame_done;
    assign ws2812_data_out = r_data;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE, S_WAIT: begin
                w_load      = r_hold_full;
                w_state_nxt = r_hold_full ? S_SHIFT : r_state;
            end
            S_SHIFT: begin
                w_load      = w_pix_end & ~r_cur_last & r_hold_full;
                w_state_nxt = !w_pix_end ? S_SHIFT : r_cur_last ? S_LATCH : r_hold_full ? S_SHIFT : S_WAIT;
            end
            S_LATCH: begin
                w_load      = w_latch_end & r_hold_full;
                w_state_nxt = !w_latch_end ? S_LATCH : r_hold_full ? S_SHIFT : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The line register samples the current bit position, so it trails the load by one edge.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= S_IDLE;
            r_hold_data  <= '0;
            r_hold_last  <= 1'b0;
            r_hold_full  <= 1'b0;
            r_shift      <= '0;
            r_cur_last   <= 1'b0;
            r_bit_idx    <= '0;
            r_cnt        <= '0;
            r_data       <= 1'b0;
            r_underrun   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_underrun   <= w_pix_end & ~r_cur_last & ~r_hold_full;
            r_frame_done <= w_latch_end;
            r_data       <= (r_state == S_SHIFT) && w_high;
            if (w_accept) begin
                r_hold_data <= pix_data_in;
                r_hold_last <= pix_last_in;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
            if (w_load) begin
                r_shift    <= r_hold_data;
                r_cur_last <= r_hold_last;
                r_bit_idx  <= 5'd23;
                r_cnt      <= '0;
            end else if (r_state == S_SHIFT) begin
                if (w_bit_end) begin
                    r_cnt     <= '0;
                    r_shift   <= {r_shift[22:0], 1'b0};
                    r_bit_idx <= r_bit_idx - 5'd1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (r_state == S_LATCH) begin
                r_cnt <= w_latch_end ? '0 : r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end
endmodule
